// File: rtl/runway_clearance_sequencer.sv
// rtl/runway_clearance_sequencer.sv - hold countdown, runway wait and one-cycle clearance issue
// Ports:
//    clk, rst             clock, asynchronous active-high reset
//    tick                 one-cycle 1 Hz strobe
//    req_valid/req_ready  request handshake; runway, gate, timer_active, timer_value latched on accept
//    clear_valid          one-cycle clearance with clear_runway / clear_gate
//    runway_busy          per-runway occupancy flags (runways 0..2)
//    holding              high in HOLD, hold_remaining is the live countdown (0 elsewhere)
//    clear_count          clearance counter, present only when CLEAR_COUNT_EN is defined
module runway_clearance_sequencer #(
   parameter int unsigned OCC_TICKS = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] allocated_runway,
   input  logic [2:0] allocated_gate,
   input  logic       timer_active,
   input  logic [3:0] timer_value,
   output logic       clear_valid,
   output logic [1:0] clear_runway,
   output logic [2:0] clear_gate,
   output logic [2:0] runway_busy,
   output logic       holding,
`ifdef CLEAR_COUNT_EN
   output logic [7:0] clear_count,
`endif
   output logic [3:0] hold_remaining
);

   typedef enum logic [1:0] {IDLE, HOLD, WAIT_RWY, CLEAR} state_t;

   state_t     state_q, state_d;
   logic [1:0] rwy_q;
   logic [2:0] gate_q;
   logic [3:0] hold_q, hold_d;
   logic [3:0] occ_q [3];
   logic [3:0] occ_d [3];
   logic [3:0] busy_ext;
   logic       accept;

   assign accept   = req_valid && (state_q == IDLE);
   // Padded so a 2-bit runway index never selects outside the vector.
   assign busy_ext = {1'b0, runway_busy};

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rwy_q   <= 2'd0;
         gate_q  <= 3'd0;
         hold_q  <= 4'd0;
         for (int n = 0; n < 3; n++) occ_q[n] <= 4'd0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         if (accept) begin
            rwy_q  <= allocated_runway;
            gate_q <= allocated_gate;
         end
         for (int n = 0; n < 3; n++) occ_q[n] <= occ_d[n];
      end
   end

   // Next-state and hold countdown
   always_comb begin
      state_d = state_q;
      hold_d  = 4'd0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (allocated_runway == 2'd3) begin
                  state_d = IDLE;
               end else if (timer_active && (timer_value != 4'd0) && (allocated_runway != 2'd0)) begin
                  // Tick in the acceptance cycle is deliberately not applied.
                  state_d = HOLD;
                  hold_d  = timer_value;
               end else begin
                  state_d = WAIT_RWY;
               end
            end
         end
         HOLD: begin
            hold_d = hold_q;
            if (tick) begin
               hold_d = hold_q - 4'd1;
               if (hold_q <= 4'd1) begin
                  state_d = WAIT_RWY;
                  hold_d  = 4'd0;
               end
            end
         end
         WAIT_RWY: begin
            if (!busy_ext[rwy_q]) state_d = CLEAR;
         end
         CLEAR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Occupancy counters: a clearance reload wins over a coincident tick on that runway.
   always_comb begin
      for (int n = 0; n < 3; n++) begin
         occ_d[n] = occ_q[n];
         if ((state_q == CLEAR) && (rwy_q == 2'(n))) begin
            occ_d[n] = 4'(OCC_TICKS);
         end else if (tick && (occ_q[n] != 4'd0)) begin
            occ_d[n] = occ_q[n] - 4'd1;
         end
      end
   end

`ifdef CLEAR_COUNT_EN
   logic [7:0] clear_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clear_count_q <= 8'd0;
      end else if (state_q == CLEAR) begin
         clear_count_q <= clear_count_q + 8'd1;
      end
   end

   assign clear_count = clear_count_q;
`endif

   // Outputs
   always_comb begin
      req_ready      = (state_q == IDLE);
      holding        = (state_q == HOLD);
      hold_remaining = (state_q == HOLD) ? hold_q : 4'd0;
      clear_valid    = (state_q == CLEAR);
      clear_runway   = (state_q == CLEAR) ? rwy_q : 2'd0;
      clear_gate     = (state_q == CLEAR) ? gate_q : 3'd0;
      for (int n = 0; n < 3; n++) runway_busy[n] = (occ_q[n] != 4'd0);
   end

endmodule

// File: tb/tb_runway_clearance_sequencer.sv
// tb/tb_runway_clearance_sequencer.sv - scoreboard bench for runway_clearance_sequencer
module tb_runway_clearance_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] allocated_runway = 2'd0;
   logic [2:0] allocated_gate = 3'd0;
   logic       timer_active = 1'b0;
   logic [3:0] timer_value = 4'd0;
   logic       clear_valid;
   logic [1:0] clear_runway;
   logic [2:0] clear_gate;
   logic [2:0] runway_busy;
   logic       holding;
   logic [3:0] hold_remaining;
`ifdef CLEAR_COUNT_EN
   logic [7:0] clear_count;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [1:0] rwy;
      logic [2:0] gate;
      int         at;
   } clr_t;

   clr_t sb[$];

   runway_clearance_sequencer #(.OCC_TICKS(5)) dut (
      .clk              (clk),
      .rst              (rst),
      .tick             (tick),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .allocated_runway (allocated_runway),
      .allocated_gate   (allocated_gate),
      .timer_active     (timer_active),
      .timer_value      (timer_value),
      .clear_valid      (clear_valid),
      .clear_runway     (clear_runway),
      .clear_gate       (clear_gate),
      .runway_busy      (runway_busy),
      .holding          (holding),
`ifdef CLEAR_COUNT_EN
      .clear_count      (clear_count),
`endif
      .hold_remaining   (hold_remaining)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic send(input logic [1:0] r, input logic [2:0] g, input logic ta,
                       input logic [3:0] tv, input logic tk);
      chk("req_ready_before_send", 32'(req_ready), 32'd1);
      req_valid        = 1'b1;
      allocated_runway = r;
      allocated_gate   = g;
      timer_active     = ta;
      timer_value      = tv;
      tick             = tk;
      @(negedge clk);
      req_valid        = 1'b0;
      allocated_runway = 2'd0;
      allocated_gate   = 3'd0;
      timer_active     = 1'b0;
      timer_value      = 4'd0;
      tick             = 1'b0;
   endtask

   task automatic push(input logic [1:0] r, input logic [2:0] g, input int at);
      clr_t e;
      e.rwy  = r;
      e.gate = g;
      e.at   = at;
      sb.push_back(e);
   endtask

   // Clearance monitor: every pulse must match the head of the scoreboard, including its cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (clear_valid) begin
            chk("clear_was_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               clr_t e;
               e = sb.pop_front();
               chk("clear_runway", 32'(clear_runway), 32'(e.rwy));
               chk("clear_gate", 32'(clear_gate), 32'(e.gate));
               chk("clear_cycle", 32'(cyc), 32'(e.at));
            end
         end else begin
            chk("idle_clear_runway", 32'(clear_runway), 32'd0);
            chk("idle_clear_gate", 32'(clear_gate), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int d;

      // Reset state
      wait_cycles(3);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_clear_valid", 32'(clear_valid), 32'd0);
      chk("rst_busy", 32'(runway_busy), 32'd0);
      chk("rst_holding", 32'(holding), 32'd0);
      chk("rst_hold_remaining", 32'(hold_remaining), 32'd0);
      rst = 1'b0;
      wait_cycles(2);

      // No hold, free runway 1
      c = cyc;
      push(2'd1, 3'd1, c + 2);
      send(2'd1, 3'd1, 1'b0, 4'd0, 1'b0);
      chk("t1_busy_accept", 32'(req_ready), 32'd0);
      wait_cycles(2);
      chk("t1_ready_back", 32'(req_ready), 32'd1);
      chk("t1_busy_set", 32'(runway_busy), 32'b010);
      for (int k = 1; k <= 5; k++) begin
         do_tick();
         chk("t1_busy_count", 32'(runway_busy), (k < 5) ? 32'b010 : 32'b000);
      end

      // Hold of 12 ticks on runway 2; tick in acceptance cycle ignored
      send(2'd2, 3'd5, 1'b1, 4'd12, 1'b1);
      chk("t2_holding", 32'(holding), 32'd1);
      chk("t2_hold_load", 32'(hold_remaining), 32'd12);
      for (int k = 1; k <= 12; k++) begin
         if (k == 12) push(2'd2, 3'd5, cyc + 2);
         do_tick();
         chk("t2_holding_step", 32'(holding), (k < 12) ? 32'd1 : 32'd0);
         chk("t2_hold_step", 32'(hold_remaining), (k < 12) ? 32'(12 - k) : 32'd0);
         if (k < 12) begin
            wait_cycles(1);
            chk("t2_hold_no_tick", 32'(hold_remaining), 32'(12 - k));
         end
      end
      wait_cycles(2);
      chk("t2_busy_set", 32'(runway_busy), 32'b100);
      repeat (5) do_tick();
      chk("t2_busy_drained", 32'(runway_busy), 32'd0);

      // Emergency runway 0 never holds
      c = cyc;
      push(2'd0, 3'd3, c + 2);
      send(2'd0, 3'd3, 1'b1, 4'd15, 1'b0);
      chk("t3_no_hold", 32'(holding), 32'd0);
      chk("t3_no_hold_cnt", 32'(hold_remaining), 32'd0);
      wait_cycles(2);
      chk("t3_busy_set", 32'(runway_busy), 32'b001);
      repeat (5) do_tick();

      // Runway 3 is dropped
      send(2'd3, 3'd7, 1'b1, 4'd5, 1'b0);
      chk("t4_drop_ready", 32'(req_ready), 32'd1);
      chk("t4_drop_hold", 32'(holding), 32'd0);
      wait_cycles(4);
      chk("t4_drop_busy", 32'(runway_busy), 32'd0);

      // Back-to-back on runway 1: second waits for release
      c = cyc;
      push(2'd1, 3'd2, c + 2);
      send(2'd1, 3'd2, 1'b0, 4'd0, 1'b0);
      wait_cycles(2);
      send(2'd1, 3'd6, 1'b0, 4'd0, 1'b0);
      wait_cycles(3);
      chk("t5_waiting_ready", 32'(req_ready), 32'd0);
      chk("t5_waiting_hold", 32'(holding), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         do_tick();
         chk("t5_busy_count", 32'(runway_busy), 32'b010);
      end
      push(2'd1, 3'd6, cyc + 2);
      do_tick();
      chk("t5_released", 32'(runway_busy), 32'd0);
      wait_cycles(2);
      chk("t5_reoccupied", 32'(runway_busy), 32'b010);
      chk("t5_ready_back", 32'(req_ready), 32'd1);
      repeat (5) do_tick();

      // Tick during CLEAR of runway 2 while runway 1 counts down
      c = cyc;
      push(2'd1, 3'd1, c + 2);
      send(2'd1, 3'd1, 1'b0, 4'd0, 1'b0);
      wait_cycles(2);
      d = cyc;
      push(2'd2, 3'd4, d + 2);
      send(2'd2, 3'd4, 1'b0, 4'd0, 1'b0);
      wait_cycles(1);
      do_tick();
      chk("t6_both_busy", 32'(runway_busy), 32'b110);
      for (int k = 1; k <= 5; k++) begin
         do_tick();
         chk("t6_busy_count", 32'(runway_busy),
             (k <= 3) ? 32'b110 : ((k == 4) ? 32'b100 : 32'b000));
      end

      // Asynchronous reset in HOLD with hold_remaining 7
      c = cyc;
      push(2'd2, 3'd1, c + 2);
      send(2'd2, 3'd1, 1'b0, 4'd0, 1'b0);
      wait_cycles(2);
      send(2'd1, 3'd2, 1'b1, 4'd9, 1'b0);
      repeat (2) do_tick();
      chk("t7_hold_7", 32'(hold_remaining), 32'd7);
      chk("t7_busy_before", 32'(runway_busy), 32'b100);
      #2;
      rst = 1'b1;
      #1;
      chk("t7_async_ready", 32'(req_ready), 32'd1);
      chk("t7_async_holding", 32'(holding), 32'd0);
      chk("t7_async_hold_cnt", 32'(hold_remaining), 32'd0);
      chk("t7_async_busy", 32'(runway_busy), 32'd0);
      chk("t7_async_clear", 32'(clear_valid), 32'd0);
      wait_cycles(2);
      rst = 1'b0;
      repeat (12) do_tick();
      chk("t7_after_ready", 32'(req_ready), 32'd1);
      chk("t7_after_busy", 32'(runway_busy), 32'd0);

`ifdef CLEAR_COUNT_EN
      chk("t8_count_reset", 32'(clear_count), 32'd0);
      for (int i = 0; i < 257; i++) begin
         c = cyc;
         push(2'(i % 3), 3'(i % 8), c + 2);
         send(2'(i % 3), 3'(i % 8), 1'b0, 4'd0, 1'b1);
         tick = 1'b1;
         wait_cycles(2);
      end
      tick = 1'b0;
      wait_cycles(1);
      chk("t8_count_wrap", 32'(clear_count), 32'd1);
`endif

      wait_cycles(4);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
